vend_dispense: RTL and testbench

//  Downstream stage of the vending controller. Accepts dispense requests (product flag + change code),

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_disp_fifo.sv | 57 +++++
 rtl/vend_dispense.sv | 167 ++++++++++++++++
 tb/tb_vend_dispense.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending dispense stage: change codes, request record, FSM states.
package vend_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_10   = 2'b01;
    localparam logic [1:0] CHG_20   = 2'b10;
    localparam logic [1:0] CHG_RSV  = 2'b11;

    typedef struct packed {
        logic       item;
        logic [1:0] change;
    } disp_req_t;

    typedef enum logic [2:0] {
        StIdle,
        StItemFire,
        StItemWait,
        StCoinFire,
        StCoinWait,
        StFault
    } disp_state_e;

    // Number of 10tk coins to eject for a change code.
    function automatic logic [1:0] coins_for(input logic [1:0] change);
        logic [1:0] n;
        case (change)
            CHG_10:  n = 2'd1;
            CHG_20:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vend_disp_fifo.sv
// Two-entry request buffer between the request interface and the dispense FSM.
module vend_disp_fifo
    import vend_pkg::*;
(
    input  logic      clk,
    input  logic      res,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  disp_req_t din,
    output disp_req_t dout,
    output logic      full,
    output logic      empty
);

    disp_req_t  mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush discards everything queued.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 2'd1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/vend_dispense.sv
// Dispense sequencer: buffers requests and fires the solenoid / coin hopper one actuation at
// a time, each confirmed by its drop sensor, with a sticky fault on a missed drop.
module vend_dispense
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       req_valid,
    input  logic       req_item,
    input  logic [1:0] req_change,
    output logic       req_ready,
    input  logic       item_drop,
    input  logic       coin_drop,
    input  logic       fault_clr,
    output logic       sol_pulse,
    output logic       coin_pulse,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned   PW          = $clog2(PULSE_CYC + 1);
    localparam int unsigned   TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0] PulseLast   = PW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

    disp_state_e   state_q, state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]    coins_q, coins_d;
    // Drop already seen during FIRE; the following WAIT cycle just retires it.
    logic          done_q, done_d;

    disp_req_t req_in;
    disp_req_t head;
    logic      push;
    logic      pop;
    logic      flush;
    logic      full;
    logic      empty;

    // Reserved change code behaves as "no change".
    always_comb begin
        req_in.item   = req_item;
        req_in.change = (req_change == CHG_RSV) ? CHG_NONE : req_change;
    end

    // Requests that would dispense nothing never enter the buffer.
    assign push      = req_valid && !full && (req_in.item || (req_in.change != CHG_NONE));
    assign req_ready = !full;
    assign busy      = (state_q != StIdle) || !empty;
    assign fault     = (state_q == StFault);

    vend_disp_fifo u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (req_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Next state, counters and actuator drives.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        coins_d     = coins_q;
        done_d      = done_q;
        pop         = 1'b0;
        flush       = 1'b0;
        sol_pulse   = 1'b0;
        coin_pulse  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop         = 1'b1;
                    coins_d     = coins_for(head.change);
                    pulse_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    done_d      = 1'b0;
                    state_d     = head.item ? StItemFire : StCoinFire;
                end
            end
            StItemFire: begin
                sol_pulse   = 1'b1;
                pulse_cnt_d = pulse_cnt_q + PW'(1);
                tmo_cnt_d   = tmo_cnt_q + TW'(1);
                if (item_drop) begin
                    done_d  = 1'b1;
                    state_d = StItemWait;
                end else if (pulse_cnt_q == PulseLast) begin
                    state_d = StItemWait;
                end
            end
            StItemWait: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (done_q || item_drop) begin
                    done_d      = 1'b0;
                    pulse_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    state_d     = (coins_q != 2'd0) ? StCoinFire : StIdle;
                end else if (tmo_cnt_q == TimeoutLast) begin
                    state_d = StFault;
                end
            end
            StCoinFire: begin
                coin_pulse  = 1'b1;
                pulse_cnt_d = pulse_cnt_q + PW'(1);
                tmo_cnt_d   = tmo_cnt_q + TW'(1);
                if (coin_drop) begin
                    coins_d = coins_q - 2'd1;
                    done_d  = 1'b1;
                    state_d = StCoinWait;
                end else if (pulse_cnt_q == PulseLast) begin
                    state_d = StCoinWait;
                end
            end
            StCoinWait: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (done_q || coin_drop) begin
                    if (!done_q) begin
                        coins_d = coins_q - 2'd1;
                    end
                    done_d      = 1'b0;
                    pulse_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    state_d     = (coins_d != 2'd0) ? StCoinFire : StIdle;
                end else if (tmo_cnt_q == TimeoutLast) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                if (fault_clr) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= StIdle;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            coins_q     <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            coins_q     <= coins_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_vend_dispense.sv
// Bench for vend_dispense: directed scenarios followed by randomized request batches checked
// against the expected sequence of actuations derived from each request.
module tb_vend_dispense;

    localparam int PULSE_CYC   = 4;
    localparam int TIMEOUT_CYC = 1000;

    logic       clk = 1'b0;
    logic       res;
    logic       req_valid;
    logic       req_item;
    logic [1:0] req_change;
    logic       req_ready;
    logic       item_drop;
    logic       coin_drop;
    logic       fault_clr;
    logic       sol_pulse;
    logic       coin_pulse;
    logic       busy;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];   // 1 = product actuation, 0 = one coin

    vend_dispense #(
        .PULSE_CYC   (PULSE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req_valid  (req_valid),
        .req_item   (req_item),
        .req_change (req_change),
        .req_ready  (req_ready),
        .item_drop  (item_drop),
        .coin_drop  (coin_drop),
        .fault_clr  (fault_clr),
        .sol_pulse  (sol_pulse),
        .coin_pulse (coin_pulse),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic checkn(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic item, input logic [1:0] chg);
        req_valid  = 1'b1;
        req_item   = item;
        req_change = chg;
        tick();
        req_valid  = 1'b0;
        req_item   = 1'b0;
        req_change = 2'b00;
    endtask

    // Wait for the next actuation, confirm its type, answer with the matching drop d cycles
    // after pulse start and check the pulse width. spur: 0 none, 1 random, 2 every cycle
    // before the drop, of the mismatched sensor.
    task automatic actuation(input bit is_item, input int d, input int spur, input string tag);
        int   t;
        int   width;
        int   other_seen;
        int   exp_w;
        logic mine;
        logic other;
        t          = 0;
        width      = 0;
        other_seen = 0;
        while (!sol_pulse && !coin_pulse && t < 40) begin
            tick();
            t++;
        end
        check1({tag, "_start"}, sol_pulse | coin_pulse, 1'b1);
        check1({tag, "_type"}, sol_pulse, is_item);
        for (int k = 0; k <= d; k++) begin
            mine  = is_item ? sol_pulse : coin_pulse;
            other = is_item ? coin_pulse : sol_pulse;
            if (mine) width++;
            if (other) other_seen++;
            if (k == d) begin
                if (is_item) item_drop = 1'b1;
                else         coin_drop = 1'b1;
            end else if (spur == 2 || (spur == 1 && $urandom_range(0, 2) == 0)) begin
                if (is_item) coin_drop = 1'b1;
                else         item_drop = 1'b1;
            end
            tick();
            item_drop = 1'b0;
            coin_drop = 1'b0;
        end
        exp_w = (d + 1 < PULSE_CYC) ? d + 1 : PULSE_CYC;
        checkn({tag, "_width"}, width, exp_w);
        checkn({tag, "_other"}, other_seen, 0);
        if (d < PULSE_CYC) begin
            check1({tag, "_deassert"}, is_item ? sol_pulse : coin_pulse, 1'b0);
        end
        check1({tag, "_nofault"}, fault, 1'b0);
    endtask

    // Expect the block to go idle shortly and stay quiet.
    task automatic settle(input string tag);
        int t;
        int seen;
        t    = 0;
        seen = 0;
        while (busy && t < 6) begin
            tick();
            t++;
        end
        check1({tag, "_idle"}, busy, 1'b0);
        check1({tag, "_fault"}, fault, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (sol_pulse || coin_pulse) seen++;
            tick();
        end
        checkn({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        logic       it;
        logic [1:0] ch;
        int         n;
        int         nc;
        int         seen;

        res        = 1'b0;
        req_valid  = 1'b0;
        req_item   = 1'b0;
        req_change = 2'b00;
        item_drop  = 1'b0;
        coin_drop  = 1'b0;
        fault_clr  = 1'b0;
        repeat (2) tick();
        check1("rst_ready", req_ready, 1'b1);
        check1("rst_busy", busy, 1'b0);
        check1("rst_fault", fault, 1'b0);
        check1("rst_sol", sol_pulse, 1'b0);
        check1("rst_coin", coin_pulse, 1'b0);
        res = 1'b1;
        tick();

        // 1: reset in the middle of a product pulse
        send(1'b1, 2'b10);
        tick();
        check1("t1_sol_on", sol_pulse, 1'b1);
        #2 res = 1'b0;
        #1;
        check1("t1_sol_async_off", sol_pulse, 1'b0);
        tick();
        res = 1'b1;
        tick();
        check1("t1_ready", req_ready, 1'b1);
        check1("t1_busy", busy, 1'b0);
        check1("t1_fault", fault, 1'b0);
        settle("t1");

        // 2: product plus 20tk change
        send(1'b1, 2'b10);
        actuation(1'b1, 6, 0, "t2_item");
        actuation(1'b0, 5, 0, "t2_coin1");
        actuation(1'b0, 5, 0, "t2_coin2");
        check1("t2_busy_after_drop", busy, 1'b0);
        settle("t2");

        // 3: buffer fills while the FSM waits on a drop; third request is refused
        send(1'b1, 2'b00);
        tick();
        check1("t3_latency", sol_pulse, 1'b1);
        repeat (6) tick();
        check1("t3_ready0", req_ready, 1'b1);
        send(1'b0, 2'b01);
        check1("t3_ready1", req_ready, 1'b1);
        send(1'b0, 2'b01);
        check1("t3_ready2", req_ready, 1'b0);
        send(1'b0, 2'b01);
        check1("t3_ready3", req_ready, 1'b0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check1("t3_clr_ignored", fault, 1'b0);
        item_drop = 1'b1;
        tick();
        item_drop = 1'b0;
        check1("t3_ready_pop_cycle", req_ready, 1'b0);
        check1("t3_busy", busy, 1'b1);
        actuation(1'b0, 2, 1, "t3_coin1");
        actuation(1'b0, 3, 0, "t3_coin2");
        settle("t3");

        // 4: missed product drop -> fault, then clear
        send(1'b1, 2'b00);
        tick();
        check1("t4_sol_on", sol_pulse, 1'b1);
        repeat (TIMEOUT_CYC - 1) tick();
        check1("t4_fault_early", fault, 1'b0);
        tick();
        check1("t4_fault", fault, 1'b1);
        check1("t4_sol_off", sol_pulse, 1'b0);
        check1("t4_ready_in_fault", req_ready, 1'b1);
        send(1'b0, 2'b01);
        check1("t4_busy_fault", busy, 1'b1);
        seen = 0;
        repeat (4) begin
            if (sol_pulse || coin_pulse) seen++;
            tick();
        end
        checkn("t4_no_actuation", seen, 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check1("t4_fault_clr", fault, 1'b0);
        check1("t4_busy_clr", busy, 1'b0);
        check1("t4_ready_clr", req_ready, 1'b1);
        settle("t4");

        // 5: empty requests are dropped; spurious product drops during coin phase ignored
        send(1'b0, 2'b11);
        send(1'b0, 2'b00);
        seen = 0;
        repeat (5) begin
            if (busy || sol_pulse || coin_pulse) seen++;
            tick();
        end
        checkn("t5_null_reqs", seen, 0);
        send(1'b0, 2'b10);
        actuation(1'b0, 2, 2, "t5_coin1");
        actuation(1'b0, 6, 2, "t5_coin2");
        settle("t5");

        // 6: drop in the first fire cycle; drop coinciding with the timeout
        send(1'b0, 2'b01);
        actuation(1'b0, 0, 0, "t6_short");
        settle("t6a");
        send(1'b1, 2'b00);
        actuation(1'b1, TIMEOUT_CYC - 1, 0, "t6_tmo_drop");
        check1("t6_tmo_busy", busy, 1'b0);
        check1("t6_tmo_fault", fault, 1'b0);
        settle("t6b");

        // Randomized batches of one or two requests issued from idle
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(1, 2);
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                it = 1'($urandom_range(0, 1));
                ch = 2'($urandom_range(0, 3));
                check1("rnd_ready", req_ready, 1'b1);
                send(it, ch);
                if (it) exp_q.push_back(1'b1);
                nc = (ch == 2'b01) ? 1 : (ch == 2'b10) ? 2 : 0;
                repeat (nc) exp_q.push_back(1'b0);
            end
            while (exp_q.size() > 0) begin
                actuation(exp_q.pop_front(), $urandom_range(0, 7), 1, "rnd");
            end
            settle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
